// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - shared bus widths, tile depths and arbiter limits
package constants_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int W_DEPTH     = 8;
  localparam int X_DEPTH     = 8;
  localparam int ARB_MAX_REQ = 8;

endpackage

// File: rtl/mem_req_arbiter_id_fifo.sv
// rtl/mem_req_arbiter_id_fifo.sv - id_fifo: synchronous FIFO holding grant IDs of in-flight requests
module id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB tells a full FIFO apart from an empty one when the index bits match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer and storage state for push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // State registers; reset flushes every stored ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin memory request arbiter with in-order response routing; MEM_ARB_LOCK_EN adds burst lock
module mem_req_arbiter
  import constants_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int OUTSTANDING = 8,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_vld,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            rsp_vld,
  input  logic [NUM_REQ-1:0]            rsp_rdy,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          m_req_vld,
  input  logic                          m_req_rdy,
  output logic [ADDR_WIDTH-1:0]         m_req_addr,
  input  logic                          m_rsp_vld,
  output logic                          m_rsp_rdy,
  input  logic [DATA_WIDTH-1:0]         m_rsp_data,
  output logic                          err_orphan,
  output logic                          busy
);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            err_orphan_q, err_orphan_d;
  logic [ID_W-1:0] grant;
  logic            found;
  logic            any_vld;
  logic            req_hs;
  logic            rsp_hs;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ID_W-1:0] head;

`ifdef MEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(W_DEPTH + 1);

  logic             lock_q, lock_d;
  logic [ID_W-1:0]  lock_id_q, lock_id_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] cnt_next;
  logic             lock_active;

  assign lock_active = lock_q && req_vld[lock_id_q];
`endif

  function automatic logic [ID_W-1:0] inc_mod(input logic [ID_W-1:0] v);
    if (v == ID_W'(NUM_REQ - 1)) return '0;
    else return v + 1'b1;
  endfunction

  assign any_vld   = |req_vld;
  assign m_req_vld = any_vld && !fifo_full;
  assign req_hs    = m_req_vld && m_req_rdy;
  assign m_rsp_rdy = !fifo_empty && rsp_rdy[head];
  assign rsp_hs    = m_rsp_vld && m_rsp_rdy;
  assign rsp_data  = m_rsp_data;
  assign busy      = !fifo_empty;
  assign err_orphan = err_orphan_q;

  // Grant: first valid requester at or after rr_ptr, wrapping; a live lock overrides the search.
  always_comb begin
    grant = rr_ptr_q;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        grant = idx[ID_W-1:0];
      end
    end
`ifdef MEM_ARB_LOCK_EN
    if (lock_active) begin
      grant = lock_id_q;
    end
`endif
  end

  // Request side outputs: address mux and one-hot ready toward the granted requester.
  always_comb begin
    m_req_addr = '0;
    req_rdy    = '0;
    if (any_vld) begin
      m_req_addr = req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
      req_rdy[grant] = m_req_rdy && !fifo_full;
    end
  end

  // Response side: only the requester whose ID heads the FIFO sees the response.
  always_comb begin
    rsp_vld = '0;
    if (m_rsp_vld && !fifo_empty) begin
      rsp_vld[head] = 1'b1;
    end
  end

  // Round-robin pointer, orphan flag and (optionally) burst lock bookkeeping.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    err_orphan_d = err_orphan_q | (m_rsp_vld & fifo_empty);
`ifdef MEM_ARB_LOCK_EN
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
    burst_cnt_d = burst_cnt_q;
    cnt_next    = '0;
    // Locked requester dropped its valid: release and let the others in next.
    if (lock_q && !lock_active) begin
      lock_d      = 1'b0;
      burst_cnt_d = '0;
      rr_ptr_d    = inc_mod(lock_id_q);
    end
    if (req_hs) begin
      cnt_next = lock_active ? burst_cnt_q + 1'b1 : CNT_W'(1);
      if (cnt_next >= CNT_W'(W_DEPTH)) begin
        lock_d      = 1'b0;
        burst_cnt_d = '0;
        rr_ptr_d    = inc_mod(grant);
      end else begin
        lock_d      = 1'b1;
        lock_id_d   = grant;
        burst_cnt_d = cnt_next;
      end
    end
`else
    if (req_hs) begin
      rr_ptr_d = inc_mod(grant);
    end
`endif
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      err_orphan_q <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
      lock_q       <= 1'b0;
      lock_id_q    <= '0;
      burst_cnt_q  <= '0;
`endif
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      err_orphan_q <= err_orphan_d;
`ifdef MEM_ARB_LOCK_EN
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      burst_cnt_q  <= burst_cnt_d;
`endif
    end
  end

  id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_hs),
    .pop   (rsp_hs),
    .din   (grant),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - scoreboard bench for mem_req_arbiter (default or MEM_ARB_LOCK_EN build)
module tb_mem_req_arbiter;
  import constants_pkg::*;

  localparam int NR = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NR-1:0]            req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [NR*ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    rsp_data, m_rsp_data;
  logic                     m_req_vld, m_req_rdy, m_rsp_vld, m_rsp_rdy;
  logic [ADDR_WIDTH-1:0]    m_req_addr;
  logic                     err_orphan, busy;

  mem_req_arbiter #(.NUM_REQ(NR), .OUTSTANDING(8)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_addr(m_req_addr),
    .m_rsp_vld(m_rsp_vld), .m_rsp_rdy(m_rsp_rdy), .m_rsp_data(m_rsp_data),
    .err_orphan(err_orphan), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [31:0] val; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  exp_t        exp_req_q[$];
  exp_t        exp_rsp_q[$];
  mem_t        mq[$];
  int          sent[NR], lim[NR], nexp[NR];
  logic [31:0] base[NR];
  int          credit, cyc, n_req_hs;
  bit          force_orphan, mon_en;
  int          n_checks, n_errors;

  function automatic logic [DATA_WIDTH-1:0] mem_data(input logic [ADDR_WIDTH-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout or unexpected event", name);
  endtask

  // Push expected request and its in-order response for each ID character.
  task automatic expect_seq(input string s);
    for (int k = 0; k < s.len(); k++) begin
      int          id;
      logic [31:0] a;
      exp_t        e;
      id = (s.getc(k) == 8'h31) ? 1 : 0;
      a  = base[id] + nexp[id];
      nexp[id]++;
      e.id = id; e.val = a;           exp_req_q.push_back(e);
      e.id = id; e.val = mem_data(a); exp_rsp_q.push_back(e);
    end
  endtask

  task automatic start(input int l0, input int l1, input logic [31:0] b0, input logic [31:0] b1, input int cr);
    @(posedge clk); #2;
    sent[0] = 0; sent[1] = 0; nexp[0] = 0; nexp[1] = 0;
    base[0] = b0; base[1] = b1; lim[0] = l0; lim[1] = l1;
    credit = cr; n_req_hs = 0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_req_q.size() != 0 || exp_rsp_q.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      fail_now(name);
      exp_req_q.delete(); exp_rsp_q.delete();
    end else begin
      check({name, "_busy"}, busy, 0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst = 1'b1;
    mq.delete(); exp_req_q.delete(); exp_rsp_q.delete();
    @(posedge clk); #3 rst = 1'b0;
  endtask

  // Requester and memory agent: observe handshakes at negedge, update drives after posedge.
  initial begin
    bit          hs_req, hs_rsp;
    int          hs_id;
    logic [31:0] hs_addr;
    mem_t        m;
    forever begin
      @(negedge clk);
      hs_req  = m_req_vld && m_req_rdy;
      hs_id   = req_rdy[1] ? 1 : 0;
      hs_addr = m_req_addr;
      hs_rsp  = m_rsp_vld && m_rsp_rdy;
      @(posedge clk); #1;
      cyc++;
      if (hs_req) begin
        sent[hs_id]++;
        n_req_hs++;
        m.addr = hs_addr; m.due = cyc + 3;
        mq.push_back(m);
      end
      if (hs_rsp && mq.size() > 0) begin
        m = mq.pop_front();
        credit--;
      end
      for (int i = 0; i < NR; i++) begin
        req_vld[i] = (sent[i] < lim[i]);
        req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = base[i] + sent[i];
      end
      if (force_orphan) begin
        m_rsp_vld = 1'b1; m_rsp_data = '0;
      end else if (mq.size() > 0 && mq[0].due <= cyc && credit > 0) begin
        m_rsp_vld = 1'b1; m_rsp_data = mem_data(mq[0].addr);
      end else begin
        m_rsp_vld = 1'b0; m_rsp_data = '0;
      end
    end
  end

  // Scoreboard monitor: compares every observed handshake with the head of the expectation queues.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (m_req_vld && m_req_rdy) begin
          if (exp_req_q.size() == 0) fail_now("unexpected_req");
          else begin
            e = exp_req_q.pop_front();
            check("req_grant", req_rdy, 64'(1) << e.id);
            check("req_addr", m_req_addr, e.val);
          end
        end
        if ((rsp_vld & rsp_rdy) != '0) begin
          if (exp_rsp_q.size() == 0) fail_now("unexpected_rsp");
          else begin
            e = exp_rsp_q.pop_front();
            check("rsp_route", rsp_vld, 64'(1) << e.id);
            check("rsp_data", rsp_data, e.val);
          end
        end
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1; req_vld = '0; req_addr = '0; rsp_rdy = '1; m_req_rdy = 1'b1;
    m_rsp_vld = 1'b0; m_rsp_data = '0; credit = 0; cyc = 0; n_req_hs = 0;
    force_orphan = 1'b0; mon_en = 1'b1; n_checks = 0; n_errors = 0;
    for (int i = 0; i < NR; i++) begin sent[i] = 0; lim[i] = 0; nexp[i] = 0; base[i] = '0; end

    // Reset and idle
    repeat (2) @(negedge clk);
    check("rst_m_req_vld", m_req_vld, 0);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_m_rsp_rdy", m_rsp_rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_err_orphan", err_orphan, 0);
    @(posedge clk); #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_m_req_vld", m_req_vld, 0);
    check("idle_busy", busy, 0);

    // Both requesters valid, in-order responses
    start(2, 2, 32'h100, 32'h200, 1000000);
`ifdef MEM_ARB_LOCK_EN
    expect_seq("0011");
`else
    expect_seq("0101");
`endif
    wait_drain("alt_drain");

    // FIFO full after 8 grants; one pop frees exactly one further grant, a cycle later
    start(5, 4, 32'h300, 32'h400, 0);
`ifdef MEM_ARB_LOCK_EN
    expect_seq("000001111");
`else
    expect_seq("010101010");
`endif
    repeat (15) @(negedge clk);
    check("full_grants", n_req_hs, 8);
    check("full_m_req_vld", m_req_vld, 0);
    check("full_req_rdy", req_rdy, 0);
    @(posedge clk); #2 credit = 1;
    t = 0;
    @(negedge clk);
    while (!(m_rsp_vld && m_rsp_rdy) && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) fail_now("pop_wait");
    else begin
      check("pop_cycle_m_req_vld", m_req_vld, 0);
      @(negedge clk);
      check("after_pop_m_req_vld", m_req_vld, 1);
      check("after_pop_grants", n_req_hs, 8);
      @(negedge clk);
      check("refull_m_req_vld", m_req_vld, 0);
      check("refull_grants", n_req_hs, 9);
    end
    @(posedge clk); #2 credit = 1000000;
    wait_drain("full_drain");

    // Head backpressure blocks the response queued behind it
    do_reset();
    @(posedge clk); #2 rsp_rdy = 2'b10;
    start(1, 1, 32'h500, 32'h600, 1000000);
    expect_seq("01");
    repeat (10) @(negedge clk);
    check("bp_m_rsp_rdy", m_rsp_rdy, 0);
    check("bp_rsp_vld", rsp_vld, 2'b01);
    check("bp_busy", busy, 1);
    @(posedge clk); #2 rsp_rdy = 2'b11;
    wait_drain("bp_drain");

    // Orphan response with empty FIFO
    @(posedge clk); #2 force_orphan = 1'b1;
    repeat (2) @(negedge clk);
    check("orphan_m_rsp_rdy", m_rsp_rdy, 0);
    check("orphan_rsp_vld", rsp_vld, 0);
    @(posedge clk); #2 force_orphan = 1'b0;
    @(negedge clk);
    check("orphan_set", err_orphan, 1);
    repeat (3) @(negedge clk);
    check("orphan_sticky", err_orphan, 1);

    // Asynchronous reset in the middle of a burst
    mon_en = 1'b0;
    start(100, 100, 32'h700, 32'h800, 0);
    repeat (6) @(negedge clk);
    check("burst_busy", busy, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    lim[0] = sent[0]; lim[1] = sent[1]; req_vld = '0;
    #1;
    check("async_busy", busy, 0);
    check("async_err_orphan", err_orphan, 0);
    check("async_m_req_vld", m_req_vld, 0);
    check("async_req_rdy", req_rdy, 0);
    check("async_rsp_vld", rsp_vld, 0);
    check("async_m_rsp_rdy", m_rsp_rdy, 0);
    mq.delete(); exp_req_q.delete(); exp_rsp_q.delete();
    @(posedge clk); #3 rst = 1'b0; mon_en = 1'b1;
    @(posedge clk); #2 force_orphan = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 force_orphan = 1'b0;
    @(negedge clk);
    check("post_rst_orphan", err_orphan, 1);

    // Long stream from requester 0 against a short one from requester 1
    do_reset();
    start(20, 4, 32'h900, 32'hA00, 1000000);
`ifdef MEM_ARB_LOCK_EN
    expect_seq("000000001111000000000000");
`else
    expect_seq("010101010000000000000000");
`endif
    wait_drain("stream_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
